// File: rtl/sig_arb_pkg.sv
// Shared types and defaults for the sigmoid share arbiter.
// Tag entries carry a fixed-width tag so the struct can live here; NUM_REQ <= 2**TAG_W_MAX.
package sig_arb_pkg;

  localparam int NUM_REQ_DEF  = 4;
  localparam int DATA_W_DEF   = 16;
  localparam int PIPE_LAT_DEF = 5;
  localparam int TAG_W_MAX    = 8;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic                 vld;
    logic [TAG_W_MAX-1:0] tag;
  } tag_ent_t;

endpackage

// File: rtl/sig_arb_rr.sv
// Round-robin picker: lowest requesting index at or after ptr wins.
// nxt_ptr is the slot after the winner; the caller decides whether to load it.
module sig_arb_rr #(
  parameter  int NUM_REQ = 4,
  localparam int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [TAG_W-1:0]   gnt_idx,
  output logic [TAG_W-1:0]   nxt_ptr
);

  int   idx;
  logic hit;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    hit     = 1'b0;
    idx     = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!hit && req[TAG_W'(idx)]) begin
        hit                = 1'b1;
        gnt[TAG_W'(idx)]   = 1'b1;
        gnt_idx            = TAG_W'(idx);
      end
    end
    nxt_ptr = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + TAG_W'(1);
  end

endmodule

// File: rtl/sigmoid_share_arbiter.sv
// Shares one fixed-latency hard-sigmoid pipe between NUM_REQ gate streams.
// Optional grant statistics: define SIG_ARB_STATS_EN.
module sigmoid_share_arbiter
  import sig_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_vld,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_rdy,
  input  logic                      flush_req,
  output logic                      flush_done,
  output logic                      sig_in_vld,
  output logic [DATA_W-1:0]         sig_in_data,
  input  logic                      sig_out_vld,
  input  logic [DATA_W-1:0]         sig_out_data,
  output logic [NUM_REQ-1:0]        rsp_vld,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      err_tag,
  output logic [NUM_REQ*16-1:0]     stat_cnt
);

  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(PIPE_LAT + 1);

  state_t               state;
  logic [CNT_W-1:0]     settle_cnt;
  logic [CNT_W-1:0]     inflight;
  logic [TAG_W-1:0]     rr_ptr, nxt_ptr, gnt_idx;
  logic [NUM_REQ-1:0]   gnt, rsp_hot;
  logic [DATA_W-1:0]    sel_data;
  logic [TAG_W_MAX-1:0] issue_tag;
  tag_ent_t             tag_pipe [PIPE_LAT];
  tag_ent_t             tag_out;
  logic                 active, take, ret, mismatch;

  sig_arb_rr #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_vld),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .nxt_ptr (nxt_ptr)
  );

  // Flush only blocks grants from the next cycle on: a grant seen with flush_req still completes.
  assign req_rdy    = (state == RUN) ? gnt : '0;
  assign take       = |req_rdy;
  assign active     = (state != SETTLE);
  assign tag_out    = tag_pipe[PIPE_LAT-1];
  assign ret        = active & sig_out_vld & tag_out.vld;
  assign mismatch   = active & (sig_out_vld ^ tag_out.vld);
  assign flush_done = (state == DRAIN) && (inflight == '0) && !sig_in_vld;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) sel_data = req_data[i*DATA_W +: DATA_W];
  end

  always_comb begin
    rsp_hot = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rsp_hot[i] = (tag_out.tag == TAG_W_MAX'(i));
  end

  // SETTLE waits out whatever the unreset sigmoid pipe still holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SETTLE;
      settle_cnt <= '0;
    end else begin
      case (state)
        SETTLE: begin
          if (settle_cnt == CNT_W'(PIPE_LAT)) state <= RUN;
          else                                settle_cnt <= settle_cnt + CNT_W'(1);
        end
        RUN:     if (flush_req)  state <= DRAIN;
        DRAIN:   if (!flush_req) state <= RUN;
        default: state <= SETTLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      sig_in_vld  <= 1'b0;
      sig_in_data <= '0;
      issue_tag   <= '0;
    end else begin
      sig_in_vld <= take;
      if (take) begin
        rr_ptr      <= nxt_ptr;
        sig_in_data <= sel_data;
        issue_tag   <= TAG_W_MAX'(gnt_idx);
      end
    end
  end

  // Tag line mirrors the sigmoid pipe depth so its output pairs with sig_out_vld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '{vld: sig_in_vld, tag: issue_tag};
      for (int i = 1; i < PIPE_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({sig_in_vld, tag_out.vld})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // A mismatched return is never routed; only the sticky error records it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld  <= '0;
      rsp_data <= '0;
      err_tag  <= 1'b0;
    end else begin
      rsp_vld <= ret ? rsp_hot : '0;
      if (ret) rsp_data <= sig_out_data;
      err_tag <= err_tag | mismatch;
    end
  end

`ifdef SIG_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    logic [15:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          cnt <= '0;
      else if (req_rdy[g] && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
    assign stat_cnt[g*16 +: 16] = cnt;
  end
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_sigmoid_share_arbiter.sv
// Scoreboard bench: sigmoid modelled as a PIPE_LAT-deep delay of a hard-sigmoid f(x).
module tb_sigmoid_share_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int L = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_vld = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_rdy;
  logic           flush_req = 1'b0;
  logic           flush_done;
  logic           sig_in_vld;
  logic [W-1:0]   sig_in_data;
  logic           sig_out_vld;
  logic [W-1:0]   sig_out_data;
  logic [N-1:0]   rsp_vld;
  logic [W-1:0]   rsp_data;
  logic           err_tag;
  logic [N*16-1:0] stat_cnt;
  logic           inject = 1'b0;

  sigmoid_share_arbiter #(.NUM_REQ(N), .DATA_W(W), .PIPE_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
    .flush_req(flush_req), .flush_done(flush_done), .sig_in_vld(sig_in_vld),
    .sig_in_data(sig_in_data), .sig_out_vld(sig_out_vld), .sig_out_data(sig_out_data),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .err_tag(err_tag), .stat_cnt(stat_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // hard sigmoid in Q3.12: clamp(x/5 + 0.5, 0, 1)
  function automatic logic [W-1:0] hsig(input logic [W-1:0] x);
    int v;
    v = 2048 + $signed(x) / 5;
    if (v < 0)    v = 0;
    if (v > 4096) v = 4096;
    return W'(v);
  endfunction

  logic [L-1:0] mp_vld = '0;
  logic [W-1:0] mp_dat [L];
  always @(posedge clk) begin
    mp_vld    <= {mp_vld[L-2:0], sig_in_vld};
    mp_dat[0] <= hsig(sig_in_data);
    for (int i = 1; i < L; i++) mp_dat[i] <= mp_dat[i-1];
  end
  assign sig_out_vld  = mp_vld[L-1] | inject;
  assign sig_out_data = mp_dat[L-1];

  typedef struct {
    int           idx;
    logic [W-1:0] data;
    int           cyc;
  } sb_t;
  sb_t sb[$];
  sb_t e_m;
  int  gcnt [N];

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_vld != '0) begin
        if (sb.size() == 0) chk("rsp_unexpected", 64'(rsp_vld), 64'd0);
        else begin
          e_m = sb.pop_front();
          chk("rsp_vld", 64'(rsp_vld), 64'(1) << e_m.idx);
          chk("rsp_data", 64'(rsp_data), 64'(e_m.data));
          chk("rsp_lat", 64'(cyc - e_m.cyc), 64'(L + 2));
        end
      end
      for (int i = 0; i < N; i++)
        if (req_vld[i] && req_rdy[i]) begin
          sb.push_back('{i, hsig(req_data[i*W +: W]), cyc});
          gcnt[i]++;
        end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [N*16-1:0] es;

  initial begin
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    req_data = {16'h8000, 16'h7FFF, 16'hF000, 16'h0800};
    repeat (2) @(negedge clk);
    chk("rst_rdy", 64'(req_rdy), 64'd0);
    chk("rst_sigv", 64'(sig_in_vld), 64'd0);
    chk("rst_sigd", 64'(sig_in_data), 64'd0);
    chk("rst_rsp", 64'({rsp_vld, rsp_data}), 64'd0);
    chk("rst_err", 64'({err_tag, flush_done}), 64'd0);
    chk("rst_stat", 64'(stat_cnt), 64'd0);

    // settle window, then round-robin 0,1,2,3,0
    @(posedge clk); #1;
    rst_n = 1'b1; req_vld = 4'b1111;
    for (int k = 0; k <= L; k++) begin
      @(negedge clk); chk("settle_rdy", 64'(req_rdy), 64'd0); step();
    end
    for (int g = 0; g < 5; g++) begin
      @(negedge clk); chk("rr_all", 64'(req_rdy), 64'(1) << (g % 4)); step();
    end
    req_vld = '0;
    wait_empty(40);

    // lone requester 2 with 1.0
    step();
    req_data[2*W +: W] = 16'h1000;
    req_vld = 4'b0100;
    @(negedge clk); chk("single_rdy", 64'(req_rdy), 64'b0100); step();
    req_vld = '0;
    wait_empty(20);

    // two requesters alternate
    step();
    req_vld = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); chk("alt_rdy", 64'(req_rdy), (k % 2 == 0) ? 64'b1000 : 64'b0010); step();
    end
    req_vld = '0;
    wait_empty(20);

    // flush with three in flight
    step();
    req_vld = 4'b1111;
    @(negedge clk); chk("fl_g0", 64'(req_rdy), 64'b0100); step();
    @(negedge clk); chk("fl_g1", 64'(req_rdy), 64'b1000); step();
    flush_req = 1'b1;
    @(negedge clk); chk("fl_g2", 64'(req_rdy), 64'b0001); step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fl_block", 64'(req_rdy), 64'd0);
      chk("fl_busy", 64'(flush_done), 64'd0);
      step();
    end
    wait_empty(20);
    chk("fl_done", 64'(flush_done), 64'd1);
    chk("fl_block_end", 64'(req_rdy), 64'd0);
    step();
    flush_req = 1'b0; req_vld = '0;
    step();
    @(negedge clk); chk("fl_exit", 64'(flush_done), 64'd0);

    // spurious sigmoid output with empty tag line
    step();
    @(negedge clk); chk("err_pre", 64'(err_tag), 64'd0);
    step(); inject = 1'b1;
    step(); inject = 1'b0;
    @(negedge clk);
    chk("err_set", 64'(err_tag), 64'd1);
    chk("err_norsp", 64'(rsp_vld), 64'd0);
    repeat (3) step();
    @(negedge clk); chk("err_sticky", 64'(err_tag), 64'd1);

    // async reset mid-stream
    step();
    req_vld = 4'b1111;
    repeat (3) step();
    @(posedge clk); #3;
    rst_n = 1'b0; req_vld = '0;
    sb.delete();
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    #1;
    chk("mrst_rdy", 64'(req_rdy), 64'd0);
    chk("mrst_sig", 64'({sig_in_vld, sig_in_data}), 64'd0);
    chk("mrst_rsp", 64'({rsp_vld, rsp_data}), 64'd0);
    chk("mrst_err", 64'({err_tag, flush_done}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; req_vld = 4'b0001;
    for (int k = 0; k <= L; k++) begin
      @(negedge clk);
      chk("mrst_settle", 64'(req_rdy), 64'd0);
      chk("mrst_noerr", 64'(err_tag), 64'd0);
      step();
    end
    @(negedge clk); chk("mrst_gnt", 64'(req_rdy), 64'b0001); step();
    req_vld = '0;
    wait_empty(20);

    for (int i = 0; i < N; i++) begin
`ifdef SIG_ARB_STATS_EN
      es[i*16 +: 16] = 16'(gcnt[i]);
`else
      es[i*16 +: 16] = 16'h0;
`endif
    end
    chk("stat_cnt", 64'(stat_cnt), 64'(es));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
